// File: rtl/exc_scheduler_pkg.sv
// Exception scheduler shared types: cause codes, FSM states and the
// interrupt line count used by the scheduler and its pending latch.
package exc_scheduler_pkg;

    localparam int IrqCount = 6;

    typedef enum logic [4:0] {
        ExcInt  = 5'd0,
        ExcSys  = 5'd8,
        ExcBp   = 5'd9,
        ExcTr   = 5'd13,
        ExcNone = 5'd31
    } ExcCodeEnum;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        HANDLER
    } ExcSchedState;

endpackage

// File: rtl/exc_scheduler_irq_pending.sv
// Interrupt edge detector and sticky pending latch.
// Ports: clock, reset (async high), irq (level lines), clear (one-hot
// delivered mask), pending (latched rising edges).
module irq_pending
    import exc_scheduler_pkg::*;
#(
    parameter int Width = IrqCount
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] irq,
    input  logic [Width-1:0] clear,
    output logic [Width-1:0] pending
);

    logic [Width-1:0] prev;

    // History resets low so a line already high at release counts as
    // an edge. A new edge wins over a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev    <= '0;
            pending <= '0;
        end else begin
            prev    <= irq;
            pending <= (pending & ~clear) | (irq & ~prev);
        end
    end

endmodule

// File: rtl/exc_scheduler.sv
// Exception scheduler: prioritises sync exceptions and latched interrupts,
// presents one cause to CP0, tracks handler residency, counts drops.
// Inputs: clock, reset, enable, syncReq{Tr,Bp,Sys}, pc, irq, irqMask, ie,
// eret, excAck. Outputs: excValid, excCode, excPc, stall, inHandler,
// dropCount.
module exc_scheduler
    import exc_scheduler_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [2:0]          syncReq,
    input  logic [31:0]         pc,
    input  logic [IrqCount-1:0] irq,
    input  logic [IrqCount-1:0] irqMask,
    input  logic                ie,
    input  logic                eret,
    input  logic                excAck,
    output logic                excValid,
    output ExcCodeEnum          excCode,
    output logic [31:0]         excPc,
    output logic                stall,
    output logic                inHandler,
    output logic [7:0]          dropCount
);

    localparam logic [IrqCount-1:0] One = IrqCount'(1);

    ExcSchedState        state;
    ExcCodeEnum          selCode;
    logic [IrqCount-1:0] pending;
    logic [IrqCount-1:0] active;
    logic [IrqCount-1:0] lowest;
    logic [IrqCount-1:0] excLine;
    logic [IrqCount-1:0] clearMask;
    logic                syncAny;
    logic                syncLost;
    logic                eligible;
    logic                dropNow;

    irq_pending #(
        .Width(IrqCount)
    ) u_pending (
        .clock  (clock),
        .reset  (reset),
        .irq    (irq),
        .clear  (clearMask),
        .pending(pending)
    );

    // irqMask bit set means the line is blocked.
    assign active   = ie ? (pending & ~irqMask) : '0;
    // Isolate the lowest-numbered active line (highest irq priority).
    assign lowest   = active & (~active + One);
    assign syncAny  = |syncReq;
    // More than one sync strobe: only the winner is taken.
    assign syncLost = (syncReq & (syncReq - 3'd1)) != 3'd0;
    assign eligible = syncAny || (|active);
    assign dropNow  = (state == IDLE) ? syncLost : syncAny;

    assign clearMask = (enable && state == PRESENT && excAck)
                     ? excLine : '0;

    always_comb begin
        selCode = ExcNone;
        if (syncReq[0])      selCode = ExcSys;
        else if (syncReq[1]) selCode = ExcBp;
        else if (syncReq[2]) selCode = ExcTr;
        else if (|active)    selCode = ExcInt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            excValid  <= 1'b0;
            excCode   <= ExcNone;
            excPc     <= '0;
            excLine   <= '0;
            stall     <= 1'b0;
            inHandler <= 1'b0;
            dropCount <= '0;
        end else if (enable) begin
            if (dropNow && dropCount != 8'hff)
                dropCount <= dropCount + 8'd1;
            case (state)
                IDLE: begin
                    if (eligible) begin
                        state    <= PRESENT;
                        excValid <= 1'b1;
                        stall    <= 1'b1;
                        excCode  <= selCode;
                        excPc    <= pc;
                        excLine  <= syncAny ? '0 : lowest;
                    end
                end
                PRESENT: begin
                    if (excAck) begin
                        state     <= HANDLER;
                        excValid  <= 1'b0;
                        stall     <= 1'b0;
                        inHandler <= 1'b1;
                    end
                end
                HANDLER: begin
                    if (eret) begin
                        state     <= IDLE;
                        inHandler <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    excValid  <= 1'b0;
                    stall     <= 1'b0;
                    inHandler <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_scheduler.sv
// Self-checking bench for exc_scheduler: directed scenarios plus a
// randomized run compared against a behavioural model.
module tb_exc_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [2:0]  syncReq = '0;
    logic [31:0] pc = '0;
    logic [5:0]  irq = '0;
    logic [5:0]  irqMask = '0;
    logic        ie = 1'b0;
    logic        eret = 1'b0;
    logic        excAck = 1'b0;
    logic        excValid;
    logic [4:0]  excCode;
    logic [31:0] excPc;
    logic        stall;
    logic        inHandler;
    logic [7:0]  dropCount;

    int checks = 0;
    int passes = 0;

    // Behavioural model state: mode 0 idle, 1 presenting, 2 in handler.
    int          mMode;
    int          mDrops;
    int          mLine;
    logic [4:0]  mCode;
    logic [31:0] mPc;
    bit   [5:0]  mPend;
    bit   [5:0]  mPrev;

    exc_scheduler dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .syncReq  (syncReq),
        .pc       (pc),
        .irq      (irq),
        .irqMask  (irqMask),
        .ie       (ie),
        .eret     (eret),
        .excAck   (excAck),
        .excValid (excValid),
        .excCode  (excCode),
        .excPc    (excPc),
        .stall    (stall),
        .inHandler(inHandler),
        .dropCount(dropCount)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        mMode  = 0;
        mDrops = 0;
        mLine  = -1;
        mCode  = 5'd31;
        mPc    = '0;
        mPend  = '0;
        mPrev  = '0;
    endtask

    task automatic model_edge();
        int         nSync;
        int         lost;
        int         line;
        logic [4:0] code;
        bit   [5:0] rise;
        bit   [5:0] clr;
        rise = irq & ~mPrev;
        clr  = '0;
        lost = 0;
        if (enable) begin
            nSync = $countones(syncReq);
            if (mMode == 0) begin
                lost = (nSync > 1) ? 1 : 0;
                code = 5'd31;
                line = -1;
                if (syncReq[0]) code = 5'd8;
                else if (syncReq[1]) code = 5'd9;
                else if (syncReq[2]) code = 5'd13;
                else if (ie) begin
                    for (int i = 5; i >= 0; i--) begin
                        if (mPend[i] && !irqMask[i]) begin
                            code = 5'd0;
                            line = i;
                        end
                    end
                end
                if (code != 5'd31) begin
                    mMode = 1;
                    mCode = code;
                    mPc   = pc;
                    mLine = line;
                end
            end else if (mMode == 1) begin
                lost = (nSync > 0) ? 1 : 0;
                if (excAck) begin
                    if (mLine >= 0) clr[mLine] = 1'b1;
                    mMode = 2;
                end
            end else begin
                lost = (nSync > 0) ? 1 : 0;
                if (eret) mMode = 0;
            end
            if (lost != 0 && mDrops < 255) mDrops++;
        end
        mPend = (mPend & ~clr) | rise;
        mPrev = irq;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enable  = 1'b1;
        syncReq = '0;
        eret    = 1'b0;
        excAck  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        irq = '0; irqMask = '0; ie = 1'b0;
        do_reset();
        checks++;
        if (excValid !== 1'b0 || excCode !== 5'd31 || excPc !== 32'h0 ||
            stall !== 1'b0 || inHandler !== 1'b0 || dropCount !== 8'd0)
            $display("FAIL reset_state got v=%b c=%0d pc=%h s=%b h=%b d=%0d",
                     excValid, excCode, excPc, stall, inHandler, dropCount);
        else passes++;
    endtask

    task automatic test_sys();
        do_reset();
        syncReq = 3'b001; pc = 32'h0040_0020;
        tick();
        syncReq = '0;
        checks++;
        if (excValid !== 1'b1 || excCode !== 5'd8 ||
            excPc !== 32'h0040_0020 || stall !== 1'b1)
            $display("FAIL sys_present got v=%b c=%0d pc=%h s=%b exp 1/8/00400020/1",
                     excValid, excCode, excPc, stall);
        else passes++;
        tick();
        checks++;
        if (excValid !== 1'b1 || excPc !== 32'h0040_0020)
            $display("FAIL sys_hold got v=%b pc=%h exp 1/00400020", excValid, excPc);
        else passes++;
        excAck = 1'b1;
        tick();
        excAck = 1'b0;
        checks++;
        if (excValid !== 1'b0 || inHandler !== 1'b1 || stall !== 1'b0)
            $display("FAIL sys_ack got v=%b h=%b s=%b exp 0/1/0",
                     excValid, inHandler, stall);
        else passes++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++;
        if (inHandler !== 1'b0 || excValid !== 1'b0)
            $display("FAIL sys_eret got h=%b v=%b exp 0/0", inHandler, excValid);
        else passes++;
    endtask

    task automatic test_bp_tr();
        do_reset();
        syncReq = 3'b110; pc = 32'h0000_1234;
        tick();
        syncReq = '0;
        checks++;
        if (excCode !== 5'd9 || excValid !== 1'b1 || dropCount !== 8'd1)
            $display("FAIL bp_priority got c=%0d v=%b d=%0d exp 9/1/1",
                     excCode, excValid, dropCount);
        else passes++;
        syncReq = 3'b001;
        tick();
        syncReq = '0;
        checks++;
        if (excCode !== 5'd9 || dropCount !== 8'd2 || excPc !== 32'h0000_1234)
            $display("FAIL present_drop got c=%0d d=%0d pc=%h exp 9/2/00001234",
                     excCode, dropCount, excPc);
        else passes++;
    endtask

    task automatic test_irq();
        do_reset();
        ie = 1'b1; irqMask = '0;
        tick();
        irq = 6'b001000; pc = 32'h0000_0400;
        tick();
        checks++;
        if (excValid !== 1'b0)
            $display("FAIL irq_latency got v=%b exp 0", excValid);
        else passes++;
        pc = 32'h0000_0404;
        tick();
        checks++;
        if (excValid !== 1'b1 || excCode !== 5'd0 || excPc !== 32'h0000_0404)
            $display("FAIL irq_present got v=%b c=%0d pc=%h exp 1/0/00000404",
                     excValid, excCode, excPc);
        else passes++;
        excAck = 1'b1;
        tick();
        excAck = 1'b0;
        checks++;
        if (inHandler !== 1'b1 || excValid !== 1'b0)
            $display("FAIL irq_ack got h=%b v=%b exp 1/0", inHandler, excValid);
        else passes++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        tick();
        checks++;
        if (excValid !== 1'b0 || inHandler !== 1'b0)
            $display("FAIL irq_cleared got v=%b h=%b exp 0/0", excValid, inHandler);
        else passes++;
        irq = '0;
        tick();
    endtask

    task automatic test_mask();
        do_reset();
        ie = 1'b1; irqMask = 6'b000100;
        irq = 6'b000100;
        tick();
        tick();
        tick();
        checks++;
        if (excValid !== 1'b0)
            $display("FAIL mask_block got v=%b exp 0", excValid);
        else passes++;
        irqMask = '0; pc = 32'h0000_0808;
        tick();
        checks++;
        if (excValid !== 1'b1 || excCode !== 5'd0 || excPc !== 32'h0000_0808)
            $display("FAIL mask_release got v=%b c=%0d pc=%h exp 1/0/00000808",
                     excValid, excCode, excPc);
        else passes++;
        irq = '0;
    endtask

    task automatic test_ie_off();
        do_reset();
        ie = 1'b0; irqMask = '0;
        irq = 6'b000001;
        tick();
        tick();
        checks++;
        if (excValid !== 1'b0)
            $display("FAIL ie_suppress got v=%b exp 0", excValid);
        else passes++;
        syncReq = 3'b100;
        tick();
        syncReq = '0;
        checks++;
        if (excValid !== 1'b1 || excCode !== 5'd13)
            $display("FAIL ie_sync got v=%b c=%0d exp 1/13", excValid, excCode);
        else passes++;
        irq = '0;
    endtask

    task automatic test_eret_drop();
        do_reset();
        syncReq = 3'b001;
        tick();
        syncReq = '0; excAck = 1'b1;
        tick();
        excAck = 1'b0;
        eret = 1'b1; syncReq = 3'b001;
        tick();
        eret = 1'b0; syncReq = '0;
        checks++;
        if (inHandler !== 1'b0 || excValid !== 1'b0 || dropCount !== 8'd1)
            $display("FAIL eret_drop got h=%b v=%b d=%0d exp 0/0/1",
                     inHandler, excValid, dropCount);
        else passes++;
        tick();
        checks++;
        if (excValid !== 1'b0)
            $display("FAIL eret_nopresent got v=%b exp 0", excValid);
        else passes++;
    endtask

    task automatic test_enable_hold();
        do_reset();
        ie = 1'b1; irqMask = '0;
        enable = 1'b0;
        irq = 6'b000010; syncReq = 3'b001;
        tick();
        syncReq = '0;
        tick();
        checks++;
        if (excValid !== 1'b0 || dropCount !== 8'd0)
            $display("FAIL enable_hold got v=%b d=%0d exp 0/0", excValid, dropCount);
        else passes++;
        enable = 1'b1; pc = 32'h0000_0c00;
        tick();
        checks++;
        if (excValid !== 1'b1 || excCode !== 5'd0 || excPc !== 32'h0000_0c00)
            $display("FAIL enable_edge got v=%b c=%0d pc=%h exp 1/0/00000c00",
                     excValid, excCode, excPc);
        else passes++;
        irq = '0;
    endtask

    task automatic test_irq_at_reset();
        ie = 1'b1; irqMask = '0; irq = 6'b100000;
        do_reset();
        tick();
        pc = 32'h0000_0f00;
        tick();
        checks++;
        if (excValid !== 1'b1 || excCode !== 5'd0 || excPc !== 32'h0000_0f00)
            $display("FAIL reset_edge got v=%b c=%0d pc=%h exp 1/0/00000f00",
                     excValid, excCode, excPc);
        else passes++;
        irq = '0;
    endtask

    task automatic test_reset_present();
        do_reset();
        syncReq = 3'b010; pc = 32'hdead_beef;
        tick();
        syncReq = '0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (excValid !== 1'b0 || excCode !== 5'd31 || excPc !== 32'h0 ||
            stall !== 1'b0 || inHandler !== 1'b0 || dropCount !== 8'd0)
            $display("FAIL reset_mid got v=%b c=%0d pc=%h s=%b h=%b d=%0d",
                     excValid, excCode, excPc, stall, inHandler, dropCount);
        else passes++;
        @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        syncReq = 3'b001;
        tick();
        syncReq = '0; excAck = 1'b1;
        tick();
        excAck = 1'b0;
        syncReq = 3'b001;
        for (int i = 0; i < 254; i++) tick();
        checks++;
        if (dropCount !== 8'd254)
            $display("FAIL sat_254 got %0d exp 254", dropCount);
        else passes++;
        tick();
        tick();
        syncReq = '0;
        checks++;
        if (dropCount !== 8'd255 || inHandler !== 1'b1)
            $display("FAIL sat_255 got d=%0d h=%b exp 255/1", dropCount, inHandler);
        else passes++;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        irq = '0; irqMask = '0; ie = 1'b1;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            enable  = ($urandom_range(0, 7) != 0);
            syncReq = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            pc      = $urandom;
            if ($urandom_range(0, 3) == 0) irq = 6'($urandom);
            if ($urandom_range(0, 7) == 0) irqMask = 6'($urandom);
            ie      = ($urandom_range(0, 5) != 0);
            eret    = ($urandom_range(0, 3) == 0);
            excAck  = ($urandom_range(0, 2) == 0);
            tick();
            if (excValid !== (mMode == 1) || stall !== (mMode == 1) ||
                inHandler !== (mMode == 2) || excCode !== mCode ||
                excPc !== mPc || dropCount !== mDrops[7:0]) begin
                if (bad < 5)
                    $display("FAIL rand_step %0d got v=%b c=%0d pc=%h h=%b d=%0d exp v=%b c=%0d pc=%h h=%b d=%0d",
                             n, excValid, excCode, excPc, inHandler, dropCount,
                             mMode == 1, mCode, mPc, mMode == 2, mDrops);
                bad++;
            end
        end
        idle_inputs();
        irq = '0;
        checks++;
        if (bad != 0)
            $display("FAIL rand_model mismatches=%0d", bad);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_sys();
        test_bp_tr();
        test_irq();
        test_mask();
        test_ie_off();
        test_eret_drop();
        test_enable_hold();
        test_irq_at_reset();
        test_reset_present();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
